// File: rtl/bram_stream_loader_pkg.sv
// Shared constants and FSM encoding for the BRAM stream loader.
// Values track the data_mover_bram bench defines.
package bram_stream_loader_pkg;

  localparam int CNT_BIT       = 31;
  localparam int AWIDTH        = 12;
  localparam int DWIDTH        = 32;
  localparam int MEM_SIZE      = 4096;
  localparam int IN_DATA_WITDH = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bram_stream_loader_pair_packer.sv
// Packs two stream elements into one {first, second} word.
// out_valid is combinational on the second beat of a pair.
module bram_stream_loader_pair_packer #(
  parameter int IW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [IW-1:0] in_data,
  output logic          out_valid,
  output logic [2*IW-1:0] out_word
);

  logic          half_q, half_d;
  logic [IW-1:0] hi_q, hi_d;

  always_comb begin
    half_d = half_q;
    hi_d   = hi_q;
    if (clr) begin
      half_d = 1'b0;
    end else if (in_valid) begin
      if (!half_q) begin
        hi_d   = in_data;
        half_d = 1'b1;
      end else begin
        half_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_q <= 1'b0;
      hi_q   <= '0;
    end else begin
      half_q <= half_d;
      hi_q   <= hi_d;
    end
  end

  assign out_valid = in_valid & half_q & ~clr;
  assign out_word  = {hi_q, in_data};

endmodule

// File: rtl/bram_stream_loader.sv
// Fills one BRAM port from a 16-bit valid/ready stream, two
// elements per 32-bit word, i_num_cnt words from i_base_addr.
module bram_stream_loader
  import bram_stream_loader_pkg::*;
#(
  parameter int CNT_BIT       = bram_stream_loader_pkg::CNT_BIT,
  parameter int DWIDTH        = bram_stream_loader_pkg::DWIDTH,
  parameter int AWIDTH        = bram_stream_loader_pkg::AWIDTH,
  parameter int MEM_SIZE      = bram_stream_loader_pkg::MEM_SIZE,
  parameter int IN_DATA_WITDH = bram_stream_loader_pkg::IN_DATA_WITDH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_run,
  input  logic [CNT_BIT-1:0]       i_num_cnt,
  input  logic [AWIDTH-1:0]        i_base_addr,
  output logic                     o_idle,
  output logic                     o_write,
  output logic                     o_done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_DATA_WITDH-1:0] s_data,
  output logic [AWIDTH-1:0]        addr_b,
  output logic                     ce_b,
  output logic                     we_b,
  output logic [DWIDTH-1:0]        d_b,
  input  logic [DWIDTH-1:0]        q_b
);

  state_e              state_q, state_d;
  logic [CNT_BIT-1:0]  cnt_q, cnt_d;
  logic [CNT_BIT-1:0]  words_q, words_d;
  logic [AWIDTH-1:0]   base_q, base_d;
  logic [AWIDTH-1:0]   addr_q, addr_d;
  logic                ce_q, ce_d;
  logic                we_q, we_d;
  logic [DWIDTH-1:0]   d_q, d_d;

  logic                start;
  logic                accept;
  logic                pk_valid;
  logic [DWIDTH-1:0]   pk_word;
  logic                unused_ok;

  assign start   = (state_q == S_IDLE) & i_run;
  assign s_ready = (state_q == S_RUN) & (words_q < cnt_q);
  assign accept  = s_valid & s_ready;

  bram_stream_loader_pair_packer #(
    .IW (IN_DATA_WITDH)
  ) u_pack (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr       (start),
    .in_valid  (accept),
    .in_data   (s_data),
    .out_valid (pk_valid),
    .out_word  (pk_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    words_d = words_q;
    base_d  = base_q;
    addr_d  = addr_q;
    d_d     = d_q;
    ce_d    = 1'b0;
    we_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_run) begin
          cnt_d   = i_num_cnt;
          base_d  = i_base_addr;
          words_d = '0;
          state_d = (i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pk_valid) begin
          ce_d    = 1'b1;
          we_d    = 1'b1;
          d_d     = pk_word;
          addr_d  = base_q + words_q[AWIDTH-1:0];
          words_d = words_q + 1'b1;
          if (words_d == cnt_q)
            state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      words_q <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      words_q <= words_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      d_q     <= d_d;
    end
  end

  assign o_idle  = (state_q == S_IDLE);
  assign o_write = (state_q == S_RUN);
  assign o_done  = (state_q == S_DONE);
  assign addr_b  = addr_q;
  assign ce_b    = ce_q;
  assign we_b    = we_q;
  assign d_b     = d_q;

  // Read port exists only to mirror data_mover_bram's port list.
  assign unused_ok = ^{q_b, MEM_SIZE[0]};

endmodule

// File: tb/tb_bram_stream_loader.sv
// Directed bench for bram_stream_loader with a BRAM model.
// Expected words and strobe timing are hand-computed.
module tb_bram_stream_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [30:0] i_num_cnt;
  logic [11:0] i_base_addr;
  logic        o_idle, o_write, o_done;
  logic        s_valid, s_ready;
  logic [15:0] s_data;
  logic [11:0] addr_b;
  logic        ce_b, we_b;
  logic [31:0] d_b;
  logic [31:0] q_b;

  logic [31:0] mem [0:4095];
  int          nwr = 0;
  int          n_chk = 0;
  int          n_err = 0;
  int          w0;

  always #5 clk = ~clk;

  bram_stream_loader dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_run       (i_run),
    .i_num_cnt   (i_num_cnt),
    .i_base_addr (i_base_addr),
    .o_idle      (o_idle),
    .o_write     (o_write),
    .o_done      (o_done),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .addr_b      (addr_b),
    .ce_b        (ce_b),
    .we_b        (we_b),
    .d_b         (d_b),
    .q_b         (q_b)
  );

  always @(posedge clk) begin
    if (ce_b && we_b) begin
      mem[addr_b] <= d_b;
      nwr <= nwr + 1;
    end
  end

  assign q_b = 32'h0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [11:0] base,
                       input logic [30:0] cnt);
    i_run       = 1'b1;
    i_base_addr = base;
    i_num_cnt   = cnt;
    tick();
    i_run       = 1'b0;
    i_base_addr = 12'd77;
    i_num_cnt   = 31'd99;
  endtask

  task automatic beat(input logic v, input logic [15:0] d);
    s_valid = v;
    s_data  = d;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    i_run       = 1'b0;
    i_num_cnt   = '0;
    i_base_addr = '0;
    s_valid     = 1'b1;
    s_data      = 16'h5555;
    tick();
    tick();
    check("rst_idle", 32'(o_idle), 1);
    check("rst_write", 32'(o_write), 0);
    check("rst_done", 32'(o_done), 0);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_strobe", {30'd0, ce_b, we_b}, 0);
    check("rst_addr", 32'(addr_b), 0);
    check("rst_data", d_b, 0);
    reset_n = 1'b1;
    s_valid = 1'b0;
    tick();
    check("idle_no_wr", 32'(nwr), 0);

    // basic load, valid always high
    w0 = nwr;
    start(12'd0, 31'd4);
    check("b_write", 32'(o_write), 1);
    check("b_ready", 32'(s_ready), 1);
    for (int i = 1; i <= 8; i++) begin
      beat(1'b1, 16'(i));
      if (i == 2) begin
        check("b_w0_ce", {30'd0, ce_b, we_b}, 3);
        check("b_w0_d", d_b, 32'h00010002);
      end
      if (i == 3)
        check("b_no_half_wr", 32'(ce_b), 0);
      if (i < 8)
        check("b_done_lo", 32'(o_done), 0);
    end
    check("b_done_hi", 32'(o_done), 1);
    check("b_last_ce", {30'd0, ce_b, we_b}, 3);
    check("b_last_addr", 32'(addr_b), 3);
    check("b_last_rdy", 32'(s_ready), 0);
    beat(1'b0, 16'h0);
    check("b_idle", 32'(o_idle), 1);
    check("b_done_1cyc", 32'(o_done), 0);
    check("b_ce_off", 32'(ce_b), 0);
    check("b_m0", mem[0], 32'h00010002);
    check("b_m1", mem[1], 32'h00030004);
    check("b_m2", mem[2], 32'h00050006);
    check("b_m3", mem[3], 32'h00070008);
    check("b_nwr", 32'(nwr - w0), 4);

    // bubbles
    w0 = nwr;
    start(12'd10, 31'd2);
    beat(1'b1, 16'hAAAA);
    beat(1'b0, 16'h1234);
    check("bb_hold_rdy", 32'(s_ready), 1);
    beat(1'b0, 16'h5678);
    beat(1'b1, 16'hBBBB);
    check("bb_w0_d", d_b, 32'hAAAABBBB);
    beat(1'b1, 16'hCCCC);
    beat(1'b0, 16'h9999);
    beat(1'b1, 16'hDDDD);
    check("bb_done", 32'(o_done), 1);
    beat(1'b0, 16'h0);
    check("bb_m10", mem[10], 32'hAAAABBBB);
    check("bb_m11", mem[11], 32'hCCCCDDDD);
    check("bb_nwr", 32'(nwr - w0), 2);

    // zero count, stream offered throughout
    w0 = nwr;
    s_valid = 1'b1;
    check("z_rdy_idle", 32'(s_ready), 0);
    start(12'd20, 31'd0);
    check("z_done", 32'(o_done), 1);
    check("z_rdy", 32'(s_ready), 0);
    check("z_ce", {30'd0, ce_b, we_b}, 0);
    tick();
    check("z_idle", 32'(o_idle), 1);
    tick();
    check("z_nwr", 32'(nwr - w0), 0);
    s_valid = 1'b0;

    // address wrap, i_run mid-run ignored
    w0 = nwr;
    start(12'd4094, 31'd4);
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        i_run     = 1'b1;
        i_num_cnt = 31'd0;
      end else begin
        i_run = 1'b0;
      end
      beat(1'b1, 16'h1000 + 16'(i));
      if (i == 6)
        check("wr_addr0", 32'(addr_b), 0);
    end
    i_run = 1'b0;
    check("wr_rdy_drop", 32'(s_ready), 0);
    check("wr_done", 32'(o_done), 1);
    beat(1'b1, 16'hFFFF);
    check("wr_idle", 32'(o_idle), 1);
    beat(1'b0, 16'h0);
    check("wr_m4094", mem[4094], 32'h10011002);
    check("wr_m4095", mem[4095], 32'h10031004);
    check("wr_m0", mem[0], 32'h10051006);
    check("wr_m1", mem[1], 32'h10071008);
    check("wr_nwr", 32'(nwr - w0), 4);

    // reset mid-run after 5 beats
    w0 = nwr;
    start(12'd100, 31'd8);
    for (int i = 1; i <= 5; i++)
      beat(1'b1, 16'h2000 + 16'(i));
    reset_n = 1'b0;
    #1;
    check("mr_idle", 32'(o_idle), 1);
    check("mr_ready", 32'(s_ready), 0);
    check("mr_strobe", {30'd0, ce_b, we_b}, 0);
    check("mr_addr", 32'(addr_b), 0);
    tick();
    tick();
    check("mr_nwr", 32'(nwr - w0), 2);
    check("mr_m100", mem[100], 32'h20012002);
    check("mr_m101", mem[101], 32'h20032004);
    reset_n = 1'b1;
    s_valid = 1'b0;
    tick();
    check("mr_rel_idle", 32'(o_idle), 1);
    w0 = nwr;
    start(12'd200, 31'd1);
    beat(1'b1, 16'hABCD);
    beat(1'b1, 16'h1234);
    check("mr_addr2", 32'(addr_b), 200);
    beat(1'b0, 16'h0);
    check("mr_m200", mem[200], 32'hABCD1234);
    check("mr_nwr2", 32'(nwr - w0), 1);
    check("mr_idle2", 32'(o_idle), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
